// File: rtl/multdiv_param.sv
// Iterative WIDTH-bit multiplier (radix-2 shift-add) / divider (non-restoring) on one shared datapath.
// Optional feature: define MULTDIV_HI_EN to add the result_hi port (upper half of the product).
module multdiv_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic             ctrl_Mult,
   input  logic             ctrl_Div,
   input  logic             is_signed,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
`ifdef MULTDIV_HI_EN
   output logic [WIDTH-1:0] result_hi,
`endif
   output logic             except,
   output logic             ready,
   output logic             busy
);

   localparam int unsigned W  = WIDTH;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W+1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  b_q, b_d;
   logic          div_q, div_d;
   logic          sgn_q, sgn_d;
   logic          neg_a_q, neg_a_d;
   logic          neg_b_q, neg_b_d;
   logic          exc_q, exc_d;
   logic [W-1:0]  result_q, result_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          except_q, except_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
`ifdef MULTDIV_HI_EN
   logic [W-1:0]  rhi_q, rhi_d;
`endif

   logic          start_c;
   logic [W-1:0]  mag_a_c, mag_b_c;
   logic [W:0]    mul_sum_c;
   logic [W+1:0]  div_sh_c, div_new_c;
   logic [PW-1:0] prod_c;
   logic [W-1:0]  rem_fix_c, quo_c, rem_c;
   logic          mul_ovf_c, div_ovf_c;

   // Datapath arithmetic: one iteration step plus the sign/fixup terms used in FIX.
   always_comb begin
      start_c   = ctrl_Mult ^ ctrl_Div;
      mag_a_c   = (is_signed && operandA[W-1]) ? W'(-operandA) : operandA;
      mag_b_c   = (is_signed && operandB[W-1]) ? W'(-operandB) : operandB;
      mul_sum_c = {1'b0, hi_q[W-1:0]} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
      // Partial remainder needs W+2 bits: it swings over [-2d, 2d) before add/subtract.
      div_sh_c  = {hi_q[W:0], lo_q[W-1]};
      div_new_c = hi_q[W+1] ? (div_sh_c + {2'b00, b_q}) : (div_sh_c - {2'b00, b_q});
      prod_c    = {hi_q[W-1:0], lo_q};
      if (sgn_q && (neg_a_q ^ neg_b_q)) begin
         prod_c = PW'(-prod_c);
      end
      mul_ovf_c = sgn_q ? (prod_c[PW-1:W] != {W{prod_c[W-1]}}) : (prod_c[PW-1:W] != '0);
      rem_fix_c = hi_q[W+1] ? (hi_q[W-1:0] + b_q) : hi_q[W-1:0];
      quo_c     = (sgn_q && (neg_a_q ^ neg_b_q)) ? W'(-lo_q) : lo_q;
      rem_c     = (sgn_q && neg_a_q) ? W'(-rem_fix_c) : rem_fix_c;
      div_ovf_c = sgn_q && neg_a_q && neg_b_q && (lo_q == MIN_VAL) && (b_q == W'(1));
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      div_d    = div_q;
      sgn_d    = sgn_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      exc_d    = exc_q;
      result_d = result_q;
      rem_d    = rem_q;
      except_d = except_q;
      ready_d  = 1'b0;
`ifdef MULTDIV_HI_EN
      rhi_d    = rhi_q;
`endif
      if (start_c) begin
         // A start in any state latches fresh operands and restarts the count.
         state_d = S_RUN;
         cnt_d   = '0;
         hi_d    = '0;
         div_d   = ctrl_Div;
         sgn_d   = is_signed;
         neg_a_d = is_signed & operandA[W-1];
         neg_b_d = is_signed & operandB[W-1];
         lo_d    = ctrl_Div ? mag_a_c : mag_b_c;
         b_d     = ctrl_Div ? mag_b_c : mag_a_c;
      end else begin
         case (state_q)
            S_RUN: begin
               cnt_d = cnt_q + CW'(1);
               if (div_q) begin
                  hi_d = div_new_c;
                  lo_d = {lo_q[W-2:0], ~div_new_c[W+1]};
               end else begin
                  hi_d = {2'b00, mul_sum_c[W:1]};
                  lo_d = {mul_sum_c[0], lo_q[W-1:1]};
               end
               if (cnt_q == CW'(W - 1)) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               if (!div_q) begin
                  lo_d  = prod_c[W-1:0];
                  hi_d  = {2'b00, prod_c[PW-1:W]};
                  exc_d = mul_ovf_c;
               end else if (b_q == '0) begin
                  lo_d  = '0;
                  hi_d  = '0;
                  exc_d = 1'b1;
               end else begin
                  lo_d  = quo_c;
                  hi_d  = {2'b00, rem_c};
                  exc_d = div_ovf_c;
               end
               state_d = S_DONE;
            end
            S_DONE: begin
               result_d = lo_q;
               rem_d    = div_q ? hi_q[W-1:0] : '0;
               except_d = exc_q;
`ifdef MULTDIV_HI_EN
               rhi_d    = div_q ? '0 : hi_q[W-1:0];
`endif
               ready_d  = 1'b1;
               state_d  = S_IDLE;
            end
            default: ;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         div_q    <= 1'b0;
         sgn_q    <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         exc_q    <= 1'b0;
         result_q <= '0;
         rem_q    <= '0;
         except_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef MULTDIV_HI_EN
         rhi_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         div_q    <= div_d;
         sgn_q    <= sgn_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         exc_q    <= exc_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         except_q <= except_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
`ifdef MULTDIV_HI_EN
         rhi_q    <= rhi_d;
`endif
      end
   end

   assign result    = result_q;
   assign remainder = rem_q;
   assign except    = except_q;
   assign ready     = ready_q;
   assign busy      = busy_q;
`ifdef MULTDIV_HI_EN
   assign result_hi = rhi_q;
`endif

endmodule

// File: tb/tb_multdiv_param.sv
// Directed bench for multdiv_param at WIDTH=32 and WIDTH=8 with a result scoreboard.
module tb_multdiv_param;

   typedef struct {
      logic [31:0] res;
      logic [31:0] rem;
      logic [31:0] hi;
      logic        exc;
      int          lat;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] a32, b32, res32, rem32;
   logic        mul32, div32, sg32, exc32, rdy32, bsy32;
   logic [7:0]  a8, b8, res8, rem8;
   logic        mul8, div8, sg8, exc8, rdy8, bsy8;
`ifdef MULTDIV_HI_EN
   logic [31:0] hi32;
   logic [7:0]  hi8;
`endif

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   multdiv_param #(.WIDTH(32)) u_dut32 (
      .clock(clock), .reset(reset), .operandA(a32), .operandB(b32),
      .ctrl_Mult(mul32), .ctrl_Div(div32), .is_signed(sg32),
      .result(res32), .remainder(rem32),
`ifdef MULTDIV_HI_EN
      .result_hi(hi32),
`endif
      .except(exc32), .ready(rdy32), .busy(bsy32)
   );

   multdiv_param #(.WIDTH(8)) u_dut8 (
      .clock(clock), .reset(reset), .operandA(a8), .operandB(b8),
      .ctrl_Mult(mul8), .ctrl_Div(div8), .is_signed(sg8),
      .result(res8), .remainder(rem8),
`ifdef MULTDIV_HI_EN
      .result_hi(hi8),
`endif
      .except(exc8), .ready(rdy8), .busy(bsy8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                    input bit is_mul, input bit sg);
      exp_t        e;
      longint      sa, sb;
      logic [63:0] p;
      int          q, r;
      e.lat = 34;
      e.hi  = '0;
      e.rem = '0;
      if (is_mul) begin
         sa = $signed(a);
         sb = $signed(b);
         if (sg) p = sa * sb;
         else    p = {32'b0, a} * {32'b0, b};
         e.res = p[31:0];
         e.hi  = p[63:32];
         e.exc = sg ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'b0);
      end else if (b == 32'd0) begin
         e.res = '0;
         e.exc = 1'b1;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
      end else if (sg) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
         e.res = q;
         e.rem = r;
         e.exc = 1'b0;
      end else begin
         e.res = a / b;
         e.rem = a % b;
         e.exc = 1'b0;
      end
      return e;
   endfunction

   task automatic wait_rdy32(output int cyc, output bit got);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clock); #1;
         cyc++;
         got = rdy32;
      end
   endtask

   task automatic wait_rdy8(output int cyc, output bit got);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(posedge clock); #1;
         cyc++;
         got = rdy8;
      end
   endtask

   task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit is_mul, input bit sg);
      exp_t e;
      int   cyc;
      bit   got;
      sbq.push_back(model32(a, b, is_mul, sg));
      @(negedge clock);
      a32 = a; b32 = b; mul32 = is_mul; div32 = !is_mul; sg32 = sg;
      @(posedge clock); #1;
      mul32 = 1'b0; div32 = 1'b0; a32 = ~a; b32 = ~b; sg32 = !sg;
      check({tag, "_busy"}, 32'(bsy32), 32'd1);
      wait_rdy32(cyc, got);
      check({tag, "_seen"}, 32'(got), 32'd1);
      e = sbq.pop_front();
      check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
      check({tag, "_res"}, res32, e.res);
      check({tag, "_rem"}, rem32, e.rem);
      check({tag, "_exc"}, 32'(exc32), 32'(e.exc));
      check({tag, "_busy_rdy"}, 32'(bsy32), 32'd0);
`ifdef MULTDIV_HI_EN
      check({tag, "_hi"}, hi32, e.hi);
`endif
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input bit is_mul, input bit sg, input exp_t ein);
      exp_t e;
      int   cyc;
      bit   got;
      sbq.push_back(ein);
      @(negedge clock);
      a8 = a; b8 = b; mul8 = is_mul; div8 = !is_mul; sg8 = sg;
      @(posedge clock); #1;
      mul8 = 1'b0; div8 = 1'b0; a8 = ~a; b8 = ~b;
      wait_rdy8(cyc, got);
      check({tag, "_seen"}, 32'(got), 32'd1);
      e = sbq.pop_front();
      check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
      check({tag, "_res"}, {24'b0, res8}, e.res);
      check({tag, "_rem"}, {24'b0, rem8}, e.rem);
      check({tag, "_exc"}, 32'(exc8), 32'(e.exc));
      check({tag, "_busy_rdy"}, 32'(bsy8), 32'd0);
`ifdef MULTDIV_HI_EN
      check({tag, "_hi"}, {24'b0, hi8}, e.hi);
`endif
   endtask

   initial begin
      exp_t e8;
      int   n_rdy;
      int   n_bsy;
      reset = 1'b1;
      a32 = '0; b32 = '0; mul32 = 1'b0; div32 = 1'b0; sg32 = 1'b0;
      a8 = '0; b8 = '0; mul8 = 1'b0; div8 = 1'b0; sg8 = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_res32", res32, 32'd0);
      check("rst_rem32", rem32, 32'd0);
      check("rst_exc32", 32'(exc32), 32'd0);
      check("rst_rdy32", 32'(rdy32), 32'd0);
      check("rst_bsy32", 32'(bsy32), 32'd0);
      check("rst_res8", {24'b0, res8}, 32'd0);
      check("rst_bsy8", 32'(bsy8), 32'd0);
      reset = 1'b0;

      run32("mul_s_7x-6",     32'd7,          32'hFFFF_FFFA, 1'b1, 1'b1);
      run32("mul_s_64kx64k",  32'h0001_0000,  32'h0001_0000, 1'b1, 1'b1);
      run32("mul_u_64kx64k",  32'h0001_0000,  32'h0001_0000, 1'b1, 1'b0);
      run32("mul_u_maxx1",    32'hFFFF_FFFF,  32'd1,         1'b1, 1'b0);
      run32("div_s_-7/2",     32'hFFFF_FFF9,  32'd2,         1'b0, 1'b1);
      run32("div_s_7/0",      32'd7,          32'd0,         1'b0, 1'b1);
      run32("div_s_min/-1",   32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b1);
      run32("div_s_7/-2",     32'd7,          32'hFFFF_FFFE, 1'b0, 1'b1);
      run32("div_u_max/7",    32'hFFFF_FFFF,  32'd7,         1'b0, 1'b0);
      run32("mul_s_-1x-1",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 1'b1);
      run32("mul_u_maxx2",    32'hFFFF_FFFF,  32'd2,         1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run32("rnd", $urandom, $urandom_range(1, 32'hFFFF), i[0], i[1]);
      end

      e8 = '{res: 32'd28, rem: 32'd4, hi: 32'd0, exc: 1'b0, lat: 10};
      run8("w8_div_u_200/7", 8'd200, 8'd7, 1'b0, 1'b0, e8);
      e8 = '{res: 32'h80, rem: 32'd0, hi: 32'hFF, exc: 1'b0, lat: 10};
      run8("w8_mul_s_-128x1", 8'h80, 8'd1, 1'b1, 1'b1, e8);

      // Abort: a multiply overtaken by a divide five cycles later.
      @(negedge clock);
      a32 = 32'd100; b32 = 32'd3; mul32 = 1'b1; sg32 = 1'b0;
      @(posedge clock); #1;
      mul32 = 1'b0;
      n_rdy = 0;
      repeat (4) begin
         @(posedge clock); #1;
         if (rdy32) n_rdy++;
      end
      check("abort_early_rdy", 32'(n_rdy), 32'd0);
      run32("abort_div_9/4", 32'd9, 32'd4, 1'b0, 1'b0);
      n_rdy = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (rdy32) n_rdy++;
      end
      check("abort_extra_rdy", 32'(n_rdy), 32'd0);

      // Reset in the middle of RUN clears outputs at once and suppresses ready.
      @(negedge clock);
      a32 = 32'd100; b32 = 32'd3; mul32 = 1'b1;
      @(posedge clock); #1;
      mul32 = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("midrst_res", res32, 32'd0);
      check("midrst_rem", rem32, 32'd0);
      check("midrst_exc", 32'(exc32), 32'd0);
      check("midrst_rdy", 32'(rdy32), 32'd0);
      check("midrst_bsy", 32'(bsy32), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      n_rdy = 0;
      repeat (50) begin
         @(posedge clock); #1;
         if (rdy32) n_rdy++;
      end
      check("midrst_no_rdy", 32'(n_rdy), 32'd0);

      // Both start controls high together are ignored.
      @(negedge clock);
      a32 = 32'd5; b32 = 32'd5; mul32 = 1'b1; div32 = 1'b1;
      @(posedge clock); #1;
      mul32 = 1'b0; div32 = 1'b0;
      check("both_ctrl_busy", 32'(bsy32), 32'd0);
      n_rdy = 0;
      n_bsy = 0;
      repeat (100) begin
         @(posedge clock); #1;
         if (rdy32) n_rdy++;
         if (bsy32) n_bsy++;
      end
      check("both_ctrl_rdy", 32'(n_rdy), 32'd0);
      check("both_ctrl_bsy_cnt", 32'(n_bsy), 32'd0);
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
